// File: rtl/md5_result_tx.sv
// md5_result_tx: serial reporter for the MD5 cracker.
// When the comparator hits or the counter runs out, this block sends one
// 8N1 status byte. After a hit it also sends the 128-bit plaintext as 16 raw
// bytes, most significant byte first. Each event produces exactly one frame.
module md5_result_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  HIT_CHAR     = 8'h46,
  parameter logic [7:0]  OVF_CHAR     = 8'h58
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data,
  input  logic         found,
  input  logic         overflow,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic [1:0]   state;
  logic         armed;
  logic         kind;      // 1 = hit frame (17 bytes), 0 = overflow frame (1 byte)
  logic [127:0] shift;     // remaining plaintext bytes, next one in [127:120]
  logic [7:0]   cur;       // byte on the line, shifted right as bits go out
  logic [15:0]  baud;
  logic [2:0]   bit_cnt;
  logic [4:0]   byte_cnt;

  logic         trigger;
  logic         baud_end;
  logic [4:0]   last_byte;

  assign trigger   = (state == IDLE) && armed && (found || overflow);
  assign baud_end  = (baud == BAUD_LAST);
  assign last_byte = kind ? 5'd16 : 5'd0;

  // Frame sequencer: arming, trigger capture, per-byte UART timing and line drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the 128-bit shift register is reset along with the control state
      // so a mid-frame reset leaves no stale plaintext behind.
      state    <= IDLE;
      armed    <= 1'b1;
      kind     <= 1'b0;
      shift    <= '0;
      cur      <= '0;
      baud     <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: every assignment in this clocked block is non-blocking, so all
      // the tests below see the values from the start of the cycle.
      done <= 1'b0;

      // Re-arm in any cycle with both flags low, including while a frame is going out.
      if (!found && !overflow) begin
        armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (trigger) begin
            armed    <= 1'b0;
            shift    <= data;
            kind     <= found;
            cur      <= found ? HIT_CHAR : OVF_CHAR;
            baud     <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            busy     <= 1'b1;
            tx       <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_cnt <= '0;
            tx      <= cur[0];
            state   <= DATA;
          end else begin
            baud <= baud + 16'd1;
          end
        end

        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              cur     <= {1'b0, cur[7:1]};
              tx      <= cur[1];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end

        STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (byte_cnt == last_byte) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              byte_cnt <= byte_cnt + 5'd1;
              cur      <= shift[127:120];
              shift    <= {shift[119:0], 8'h00};
              tx       <= 1'b0;
              state    <= START;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md5_result_tx.sv
// Bench for md5_result_tx. The reference model derives the expected tx level
// for every cycle of a frame from the byte list alone. Each bit slot is
// CLKS_PER_BIT cycles long, each byte is {start, 8 data bits LSB first, stop},
// and the bytes are sent back to back.
module tb_md5_result_tx;

  localparam int         CPB = 4;
  localparam logic [7:0] HIT = 8'h46;
  localparam logic [7:0] OVF = 8'h58;

  typedef struct {
    logic         f;
    logic         o;
    logic [127:0] d;
    logic [7:0]   status;
    int           nbytes;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] data = '0;
  logic         found = 1'b0;
  logic         overflow = 1'b0;
  logic         tx, busy, done;

  int           tests = 0;
  int           fails = 0;
  logic [7:0]   exp_q[$];
  vec_t         vecs[3];
  int           hold;

  md5_result_tx #(
    .CLKS_PER_BIT(CPB),
    .HIT_CHAR    (HIT),
    .OVF_CHAR    (OVF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data    (data),
    .found   (found),
    .overflow(overflow),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void expect_hit(input logic [127:0] d);
    exp_q.delete();
    exp_q.push_back(HIT);
    for (int i = 0; i < 16; i++) exp_q.push_back(d[127 - 8*i -: 8]);
  endfunction

  function automatic void expect_ovf();
    exp_q.delete();
    exp_q.push_back(OVF);
  endfunction

  // Expected line level k cycles after the trigger cycle (k >= 1).
  function automatic logic model_tx(input int k);
    int idx = (k - 1) / CPB;
    int pos = idx % 10;
    logic [7:0] b8 = exp_q[idx / 10];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b8[pos - 1];
  endfunction

  // Called between the trigger cycle's negedge and the next posedge. Checks up
  // to `limit` frame cycles. For a full frame it also checks the done cycle.
  task automatic check_frame(input string name, input int limit);
    int len = exp_q.size() * 10 * CPB;
    int n = (limit < len) ? limit : len;
    int tx_err = 0, busy_err = 0, done_err = 0, first = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (tx !== model_tx(k)) begin
        tx_err++;
        if (first < 0) first = k;
      end
      if (busy !== 1'b1) busy_err++;
      if (done !== 1'b0) done_err++;
    end
    if (first >= 0) $display("note %s: first tx deviation at frame cycle %0d", name, first);
    check({name, "_tx_errors"}, tx_err, 0);
    check({name, "_busy_low_cycles"}, busy_err, 0);
    check({name, "_early_done"}, done_err, 0);
    if (n == len) begin
      @(negedge clk);
      check({name, "_end_tx_busy_done"}, {tx, busy, done}, 3'b101);
    end
  endtask

  task automatic fire(input logic f, input logic o, input logic [127:0] d);
    @(posedge clk); #1;
    found = f; overflow = o; data = d;
    @(negedge clk);
  endtask

  task automatic drop_flags();
    @(posedge clk); #1;
    found = 1'b0; overflow = 1'b0;
  endtask

  task automatic watch_quiet(input string name, input int n);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    check({name, "_active_cycles"}, bad, 0);
  endtask

  initial begin
    logic [127:0] d;
    logic         f, o;
    int           mode;

    // Reset state.
    #12;
    check("reset_outputs", {tx, busy, done}, 3'b100);
    @(posedge clk); #1 rst = 1'b1;
    watch_quiet("post_reset_idle", 3);

    // Table-driven: flag combinations and the resulting frame.
    vecs[0] = '{f: 1'b1, o: 1'b0, d: 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, status: HIT, nbytes: 17};
    vecs[1] = '{f: 1'b0, o: 1'b1, d: 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, status: OVF, nbytes: 1};
    vecs[2] = '{f: 1'b1, o: 1'b1, d: 128'h80000000_00000000_00000000_00000001, status: HIT, nbytes: 17};
    for (int i = 0; i < 3; i++) begin
      fire(vecs[i].f, vecs[i].o, vecs[i].d);
      exp_q.delete();
      exp_q.push_back(vecs[i].status);
      for (int j = 0; j < vecs[i].nbytes - 1; j++) exp_q.push_back(vecs[i].d[127 - 8*j -: 8]);
      check_frame($sformatf("vec%0d", i), 1 << 30);
      drop_flags();
      repeat (3) @(posedge clk);
    end

    // 1: one-cycle found pulse, full 17-byte hit frame.
    d = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    fire(1'b1, 1'b0, d);
    expect_hit(d);
    fork
      check_frame("t1", 1 << 30);
      begin @(posedge clk); #1 found = 1'b0; end
    join
    repeat (2) @(posedge clk);

    // 2: overflow held high -> a single frame, and a new one only after a drop.
    d = {$urandom, $urandom, $urandom, $urandom};
    fire(1'b0, 1'b1, d);
    expect_ovf();
    check_frame("t2", 1 << 30);
    watch_quiet("t2_held", 950);
    drop_flags();
    fire(1'b0, 1'b1, d);
    check_frame("t2_refire", 1 << 30);
    drop_flags();
    repeat (2) @(posedge clk);

    // 3: both flags together -> hit frame only, nothing more while both stay high.
    d = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    fire(1'b1, 1'b1, d);
    expect_hit(d);
    check_frame("t3", 1 << 30);
    watch_quiet("t3_held", 200);
    drop_flags();
    repeat (2) @(posedge clk);

    // 4: data changes after the trigger must not reach the line.
    d = 128'h0123_4567_89AB_CDEF_1122_3344_5566_7788;
    fire(1'b1, 1'b0, d);
    expect_hit(d);
    fork
      check_frame("t4", 1 << 30);
      begin repeat (5) @(posedge clk); #1 data = ~d; end
    join
    drop_flags();
    repeat (2) @(posedge clk);

    // 5: asynchronous reset in the middle of byte 3, then a fresh frame with found still high.
    d = 128'hCAFEBABE_00000000_11111111_22222222;
    fire(1'b1, 1'b0, d);
    expect_hit(d);
    check_frame("t5_partial", 3 * 10 * CPB + 15);
    #2 rst = 1'b0;
    #1 check("t5_async_reset", {tx, busy, done}, 3'b100);
    @(posedge clk); #1;
    rst  = 1'b1;
    d    = 128'h13579BDF_2468ACE0_FEEDFACE_87654321;
    data = d;
    @(negedge clk);
    expect_hit(d);
    check_frame("t5_fresh", 1 << 30);
    drop_flags();
    repeat (2) @(posedge clk);

    // 6: re-arm during frame 1 -> frame 2 starts the cycle after done.
    d = 128'h0000FFFF_0000FFFF_0000FFFF_0000FFFF;
    fire(1'b1, 1'b0, d);
    expect_hit(d);
    fork
      check_frame("t6_first", 1 << 30);
      begin
        @(posedge clk); #1 found = 1'b0;
        repeat (100) @(posedge clk); #1 found = 1'b1;
        @(posedge clk); #1 found = 1'b0;
        @(posedge clk); #1 found = 1'b1; data = 128'h55AA55AA_AA55AA55_12345678_9ABCDEF0;
      end
    join
    expect_hit(128'h55AA55AA_AA55AA55_12345678_9ABCDEF0);
    check_frame("t6_second", 1 << 30);
    drop_flags();
    repeat (2) @(posedge clk);

    // Randomized events checked against the model.
    for (int r = 0; r < 6; r++) begin
      d    = {$urandom, $urandom, $urandom, $urandom};
      mode = $urandom_range(0, 2);
      f    = (mode != 1);
      o    = (mode != 0);
      hold = $urandom_range(1, 30);
      fire(f, o, d);
      if (f) expect_hit(d);
      else   expect_ovf();
      fork
        check_frame($sformatf("rand%0d", r), 1 << 30);
        begin
          repeat (hold) @(posedge clk);
          #1 found = 1'b0; overflow = 1'b0; data = {$urandom, $urandom, $urandom, $urandom};
        end
      join
      repeat ($urandom_range(1, 5)) @(posedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
